wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and load scoreboard between the execute/memory stages and the register file. Merges single-cycle ALU results and in-order load returns into one registered write port (`wb`, `dst`, `reg_write`) that drives the register file directly. Tracks destinations of outstanding loads and raises `stall` to decode on read-after-write hazards.

## Interface

No parameters. Depth of load queue fixed at 2, register count fixed at 32.

- `CLOCK_50` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_ready` out 1: arbiter can accept an ALU result.
- `alu_dst` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `ld_issue` in 1: load issued to memory this cycle.
- `ld_ready` out 1: load queue can accept an issue.
- `ld_dst` in 5: destination of issuing load.
- `ld_valid` in 1: load data returning, in issue order.
- `ld_data` in 32: returned load data.
- `src_a`, `src_b` in 5: decode source registers.
- `stall` out 1: decode must hold.
- `wb` out 32: write data to register file.
- `dst` out 5: write address to register file.
- `reg_write` out 1: write enable to register file.
- `err` out 1: sticky protocol error.
- Under `WB_FWD_EN` only: `fwd_a_hit`, `fwd_b_hit` out 1; `fwd_a_data`, `fwd_b_data` out 32.

## Operation

- Load queue: 2-entry FIFO of `{valid, dst}`. Push on `ld_issue && ld_ready`; pop on `ld_valid` with queue non-empty. `ld_ready` = queue not full, or full and popping this cycle.
- ALU hold register: 1 entry. An ALU result that cannot go out this cycle is captured there; `alu_ready` = hold empty.
- Output select per cycle, priority: load return > held ALU result > incoming ALU result. Winner registered onto `wb`/`dst`/`reg_write`; if nothing selected, `reg_write` = 0 (`wb`, `dst` hold value).
- WAW ordering: an ALU result (held or incoming) whose dst matches any valid load-queue entry is not released; it waits in the hold register until no matching entry remains.
- Destination x0: the result is consumed normally, but `reg_write` is driven 0.
- Busy(r) = r != 0 and (r matches any valid queue entry, or matches a valid hold entry, or equals `dst` with `reg_write` = 1 unless `WB_FWD_EN`).
- `stall` = Busy(`src_a`) or Busy(`src_b`). Combinational.
- `ld_valid` with empty queue: data dropped, `err` set. `ld_issue` while full and not popping: ignored, `err` set. `err` clears only on reset.
- Duplicate in-flight loads to the same dst: each entry is tracked separately; busy until both retire.

## Timing

- Reset (async assert, sync-safe deassert): queue and hold empty; `reg_write` = 0, `wb` = 0, `dst` = 0, `err` = 0, `stall` = 0, `alu_ready` = 1, `ld_ready` = 1.
- Latency: a selected result in cycle N appears on the outputs in cycle N+1, with `reg_write` high for exactly one cycle. The register file writes it at the end of N+1.
- Load with `ld_valid` in cycle N clears its busy bit at the N to N+1 edge. `stall` for that source then comes from the output stage until the end of N+1, or is removed at N+1 under `WB_FWD_EN`.
- ALU result losing to a load in cycle N sits in the hold register; the earliest release is cycle N+1.
- Simultaneous push and pop on a full queue is allowed; occupancy stays at 2.
- Reset mid-operation discards queued loads and held results; no write is emitted.

## Configuration

- `WB_FWD_EN` defined:
  - `fwd_x_hit` = (`src_x` != 0 and `reg_write` and `src_x` == `dst`).
  - `fwd_x_data` = `wb`.
  - The output stage is excluded from Busy.
- `WB_FWD_EN` undefined:
  - The `fwd_*` ports do not exist.
  - The output stage counts in Busy, costing one extra stall cycle per dependency.

## Test plan

- **Reset:** hold `rst_n` = 0 with random inputs.
  - Required: `reg_write` = 0, `stall` = 0, `alu_ready` = `ld_ready` = 1, `err` = 0.
- **ALU to register file:** `alu_valid`, `alu_dst` = 5, `alu_data` = 0x1234 in cycle 0.
  - Required: cycle 1 shows `reg_write` = 1, `dst` = 5, `wb` = 0x1234; cycle 2 shows `reg_write` = 0.
- **Load/ALU collision:** issue a load to x7; later drive `ld_valid` (`ld_data` = 0xAA) and ALU x3 = 0x55 in the same cycle.
  - Required: x7 = 0xAA written first, then x3 = 0x55 the next cycle.
  - Required: `alu_ready` = 0 for one cycle.
- **Stall:** issue a load to x9, set `src_a` = 9.
  - Required: `stall` = 1 until the return.
  - Without `WB_FWD_EN`, one more cycle after the write appears.
  - With `WB_FWD_EN`: `fwd_a_hit` = 1, `fwd_a_data` = load data.
- **WAW and full queue:** issue two loads to x4, then ALU result to x4, then a third issue.
  - Required: `ld_ready` = 0 on the third issue.
  - Required: ALU x4 is written after both loads retire.
  - Required: `src_b` = 4 stalls throughout.
- **Error and x0:** `ld_valid` with empty queue.
  - Required: `err` = 1 and stays set.
- **ALU to x0:** ALU result to x0.
  - Required: `reg_write` stays 0 and `stall` stays 0 with `src_a` = 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results and in-order load returns, with load scoreboard
// Optional WB_FWD_EN adds output-stage forwarding ports and removes the output stage from the hazard check.
module wb_arbiter (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_dst,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    output logic        ld_ready,
    input  logic [4:0]  ld_dst,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    output logic        stall,
    output logic [31:0] wb,
    output logic [4:0]  dst,
    output logic        reg_write,
    output logic        err
`ifdef WB_FWD_EN
    ,
    output logic        fwd_a_hit,
    output logic        fwd_b_hit,
    output logic [31:0] fwd_a_data,
    output logic [31:0] fwd_b_data
`endif
);

    // Load queue is a shift FIFO: entry 0 is always the oldest outstanding load.
    logic [1:0]  q_valid;
    logic [4:0]  q_dst [2];

    logic        hold_valid;
    logic [4:0]  hold_dst;
    logic [31:0] hold_data;

    logic        pop;
    logic        push;
    logic        alu_take;
    logic        hold_waw;
    logic        alu_waw;
    logic        sel_valid;
    logic [4:0]  sel_dst;
    logic [31:0] sel_data;
    logic        hold_release;
    logic        hold_capture;
    logic        out_busy_en;

    assign pop       = ld_valid && q_valid[0];
    assign ld_ready  = !q_valid[1] || pop;
    assign push      = ld_issue && ld_ready;
    assign alu_ready = !hold_valid;
    assign alu_take  = alu_valid && alu_ready;

    assign hold_waw = (q_valid[0] && (q_dst[0] == hold_dst)) ||
                      (q_valid[1] && (q_dst[1] == hold_dst));
    assign alu_waw  = (q_valid[0] && (q_dst[0] == alu_dst)) ||
                      (q_valid[1] && (q_dst[1] == alu_dst));

`ifdef WB_FWD_EN
    assign out_busy_en = 1'b0;
    assign fwd_a_hit   = (src_a != 5'd0) && reg_write && (src_a == dst);
    assign fwd_b_hit   = (src_b != 5'd0) && reg_write && (src_b == dst);
    assign fwd_a_data  = wb;
    assign fwd_b_data  = wb;
`else
    assign out_busy_en = 1'b1;
`endif

    function automatic logic is_busy(
        input logic [4:0] r,
        input logic [1:0] qv,
        input logic [4:0] qd0,
        input logic [4:0] qd1,
        input logic       hv,
        input logic [4:0] hd,
        input logic       ov,
        input logic [4:0] od
    );
        return (r != 5'd0) &&
               ((qv[0] && (qd0 == r)) || (qv[1] && (qd1 == r)) ||
                (hv && (hd == r)) || (ov && (od == r)));
    endfunction

    assign stall = is_busy(src_a, q_valid, q_dst[0], q_dst[1], hold_valid, hold_dst,
                           out_busy_en && reg_write, dst) ||
                   is_busy(src_b, q_valid, q_dst[0], q_dst[1], hold_valid, hold_dst,
                           out_busy_en && reg_write, dst);

    // Priority: load return, then held ALU result, then incoming ALU result.
    always_comb begin
        sel_valid    = 1'b0;
        sel_dst      = hold_dst;
        sel_data     = hold_data;
        hold_release = 1'b0;
        hold_capture = 1'b0;
        if (pop) begin
            sel_valid    = 1'b1;
            sel_dst      = q_dst[0];
            sel_data     = ld_data;
            hold_capture = alu_take;
        end else if (hold_valid && !hold_waw) begin
            sel_valid    = 1'b1;
            hold_release = 1'b1;
        end else if (alu_take && !alu_waw) begin
            sel_valid    = 1'b1;
            sel_dst      = alu_dst;
            sel_data     = alu_data;
        end else begin
            hold_capture = alu_take;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            q_valid    <= 2'b00;
            q_dst[0]   <= 5'd0;
            q_dst[1]   <= 5'd0;
            hold_valid <= 1'b0;
            hold_dst   <= 5'd0;
            hold_data  <= 32'd0;
            reg_write  <= 1'b0;
            wb         <= 32'd0;
            dst        <= 5'd0;
            err        <= 1'b0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    q_valid  <= {1'b0, q_valid[1]};
                    q_dst[0] <= q_dst[1];
                end
                2'b10: begin
                    if (!q_valid[0]) begin
                        q_valid[0] <= 1'b1;
                        q_dst[0]   <= ld_dst;
                    end else begin
                        q_valid[1] <= 1'b1;
                        q_dst[1]   <= ld_dst;
                    end
                end
                2'b11: begin
                    if (q_valid[1]) begin
                        q_dst[0] <= q_dst[1];
                        q_dst[1] <= ld_dst;
                    end else begin
                        q_dst[0] <= ld_dst;
                    end
                end
                default: ;
            endcase

            if (hold_capture) begin
                hold_valid <= 1'b1;
                hold_dst   <= alu_dst;
                hold_data  <= alu_data;
            end else if (hold_release) begin
                hold_valid <= 1'b0;
            end

            // x0 results are consumed but never written.
            reg_write <= sel_valid && (sel_dst != 5'd0);
            if (sel_valid) begin
                wb  <= sel_data;
                dst <= sel_dst;
            end

            if ((ld_valid && !q_valid[0]) || (ld_issue && !ld_ready))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - table-driven bench for wb_arbiter
module tb_wb_arbiter;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLOCK_50;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic        ld_ready;
    logic [4:0]  ld_dst;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        stall;
    logic [31:0] wb;
    logic [4:0]  dst;
    logic        reg_write;
    logic        err;
`ifdef WB_FWD_EN
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;
`endif

    wb_arbiter dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .ld_issue  (ld_issue),
        .ld_ready  (ld_ready),
        .ld_dst    (ld_dst),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .src_a     (src_a),
        .src_b     (src_b),
        .stall     (stall),
        .wb        (wb),
        .dst       (dst),
        .reg_write (reg_write),
        .err       (err)
`ifdef WB_FWD_EN
        ,
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_a_data(fwd_a_data),
        .fwd_b_data(fwd_b_data)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit          rst;
        bit          av;
        logic [4:0]  ad;
        logic [31:0] adat;
        bit          li;
        logic [4:0]  ldd;
        bit          lv;
        logic [31:0] ldat;
        logic [4:0]  sa;
        logic [4:0]  sb;
        bit          e_rw;
        logic [4:0]  e_dst;
        logic [31:0] e_wb;
        bit          e_stall;
        bit          fwd_drop;
        bit          e_ar;
        bit          e_lr;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(bit r, bit av, logic [4:0] ad, logic [31:0] adat,
                                bit li, logic [4:0] ldd, bit lv, logic [31:0] ldat,
                                logic [4:0] sa, logic [4:0] sb,
                                bit erw, logic [4:0] ed, logic [31:0] ew,
                                bit est, bit fdrop, bit ear, bit elr, bit eerr);
        vec_t v;
        v.rst = r; v.av = av; v.ad = ad; v.adat = adat;
        v.li = li; v.ldd = ldd; v.lv = lv; v.ldat = ldat;
        v.sa = sa; v.sb = sb;
        v.e_rw = erw; v.e_dst = ed; v.e_wb = ew;
        v.e_stall = est; v.fwd_drop = fdrop;
        v.e_ar = ear; v.e_lr = elr; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
        end
    endtask

    task automatic randomize_inputs();
        alu_valid = 1'($urandom);
        alu_dst   = 5'($urandom);
        alu_data  = $urandom;
        ld_issue  = 1'($urandom);
        ld_dst    = 5'($urandom);
        ld_valid  = 1'($urandom);
        ld_data   = $urandom;
        src_a     = 5'($urandom);
        src_b     = 5'($urandom);
    endtask

    initial begin
        // ALU to register file
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,1,5,'h1234, 0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        5,0,  1,5,'h1234,     1,1, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,0));
        // load/ALU collision
        vecs.push_back(mk(0,0,0,0,      1,7,0,0,        0,0,  0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        7,0,  0,0,0,          1,0, 1,1,0));
        vecs.push_back(mk(0,1,3,'h55,   0,0,1,'hAA,     7,0,  0,0,0,          1,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        7,3,  1,7,'hAA,       1,0, 0,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,3,  1,3,'h55,       1,1, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,0));
        // stall on outstanding load
        vecs.push_back(mk(0,0,0,0,      1,9,0,0,        9,0,  0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        9,0,  0,0,0,          1,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        9,0,  0,0,0,          1,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,1,'hBEEF,   9,0,  0,0,0,          1,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        9,0,  1,9,'hBEEF,     1,1, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        9,0,  0,0,0,          0,0, 1,1,0));
        // WAW, full queue, push+pop on full
        vecs.push_back(mk(0,0,0,0,      1,4,0,0,        0,4,  0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      1,4,0,0,        0,4,  0,0,0,          1,0, 1,1,0));
        vecs.push_back(mk(0,1,4,'h44,   0,0,0,0,        0,4,  0,0,0,          1,0, 1,0,0));
        vecs.push_back(mk(0,0,0,0,      1,6,0,0,        0,4,  0,0,0,          1,0, 0,0,0));
        vecs.push_back(mk(0,0,0,0,      1,8,1,'h41,     0,4,  0,0,0,          1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,1,'h42,     0,4,  1,4,'h41,       1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,1,'h88,     0,4,  1,4,'h42,       1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,4,  1,8,'h88,       1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,4,  1,4,'h44,       1,1, 1,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,1));
        // reset with a queued load and a held result
        vecs.push_back(mk(0,0,0,0,      1,10,0,0,       10,0, 0,0,0,          0,0, 1,1,1));
        vecs.push_back(mk(0,1,10,'h77,  0,0,0,0,        10,0, 0,0,0,          1,0, 1,1,1));
        vecs.push_back(mk(1,1,10,'h99,  1,3,1,'h5,      10,3, 0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        10,0, 0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,0));
        // load return with empty queue
        vecs.push_back(mk(0,0,0,0,      0,0,1,'hEE,     0,0,  0,0,0,          0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,1));
        // ALU to x0
        vecs.push_back(mk(0,1,0,'hDEAD, 0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,1));
        vecs.push_back(mk(0,0,0,0,      0,0,0,0,        0,0,  0,0,0,          0,0, 1,1,1));

        rst_n = 1'b0;
        randomize_inputs();
        repeat (3) begin
            @(negedge CLOCK_50);
            randomize_inputs();
        end
        #2;
        chk("reset reg_write", -1, 32'(reg_write), 32'd0);
        chk("reset stall",     -1, 32'(stall),     32'd0);
        chk("reset alu_ready", -1, 32'(alu_ready), 32'd1);
        chk("reset ld_ready",  -1, 32'(ld_ready),  32'd1);
        chk("reset err",       -1, 32'(err),       32'd0);
        chk("reset wb",        -1, wb,             32'd0);
        chk("reset dst",       -1, 32'(dst),       32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            bit   exp_stall;
            v = vecs[i];
            @(negedge CLOCK_50);
            rst_n     = !v.rst;
            alu_valid = v.av;
            alu_dst   = v.ad;
            alu_data  = v.adat;
            ld_issue  = v.li;
            ld_dst    = v.ldd;
            ld_valid  = v.lv;
            ld_data   = v.ldat;
            src_a     = v.sa;
            src_b     = v.sb;
            #2;
            exp_stall = v.e_stall && !(FWD && v.fwd_drop);
            chk("reg_write", i, 32'(reg_write), 32'(v.e_rw));
            if (v.e_rw) begin
                chk("dst", i, 32'(dst), 32'(v.e_dst));
                chk("wb",  i, wb,       v.e_wb);
            end
            chk("stall",     i, 32'(stall),     32'(exp_stall));
            chk("alu_ready", i, 32'(alu_ready), 32'(v.e_ar));
            chk("ld_ready",  i, 32'(ld_ready),  32'(v.e_lr));
            chk("err",       i, 32'(err),       32'(v.e_err));
`ifdef WB_FWD_EN
            chk("fwd_a_hit", i, 32'(fwd_a_hit),
                32'(v.e_rw && (v.sa != 5'd0) && (v.sa == v.e_dst)));
            chk("fwd_b_hit", i, 32'(fwd_b_hit),
                32'(v.e_rw && (v.sb != 5'd0) && (v.sb == v.e_dst)));
            if (v.e_rw && (v.sa != 5'd0) && (v.sa == v.e_dst))
                chk("fwd_a_data", i, fwd_a_data, v.e_wb);
            if (v.e_rw && (v.sb != 5'd0) && (v.sb == v.e_dst))
                chk("fwd_b_data", i, fwd_b_data, v.e_wb);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
